tape_mode_ctl: RTL

Tape-interface mode controller for the Speccy core: turns the ULA's LOAD (F12) and SAVE (F11) toggle keys into a three-state tape mode with synchronisation and debounce. It drives port_5F_in mode bits, pulses the tape-FIFO clear, and can leave LOAD mode automatically after the FIFO stays empty for a set time. It is the parametrised, multi-mode successor to the single-toggle load-mode controller and sits between the ULA key decode and the tape reader FIFO.

---
 rtl/tape_pkg.sv | 18 +
 rtl/key_debounce.sv | 60 ++++++
 rtl/tape_mode_ctl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// Shared tape-mode types and 60 MHz default timing constants.
// Pure declarations: no latency and no flow control.
package tape_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_SAVE = 2'd2
    } tape_mode_t;

    localparam int unsigned TAPE_SYNC_STAGES      = 2;
    localparam int unsigned TAPE_DEBOUNCE_W       = 20;
    localparam int unsigned TAPE_DEBOUNCE_CYCLES  = 600000;     // 10 ms
    localparam int unsigned TAPE_CLR_PULSE_CYCLES = 4;
    localparam int unsigned TAPE_TIMEOUT_W        = 32;
    localparam int unsigned TAPE_TIMEOUT_CYCLES   = 300000000;  // 5 s

endpackage

// File: rtl/key_debounce.sv
// Synchronise, debounce and edge-detect one asynchronous key level.
// o_press is a one-cycle strobe SYNC_STAGES+DEBOUNCE_CYCLES edges after a clean rise; no backpressure.
module key_debounce
    import tape_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = TAPE_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_W      = TAPE_DEBOUNCE_W,
    parameter int unsigned DEBOUNCE_CYCLES = TAPE_DEBOUNCE_CYCLES
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_key,
    output logic o_press
);

    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic [DEBOUNCE_W-1:0]  cnt_q;
    logic                   filt_q;
    logic                   armed_q;
    logic                   press_q;
    logic                   synced;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign o_press = press_q;

    // armed_q blocks a press from a key that was already held during reset:
    // it only sets once the flushed synchroniser has seen the key released.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_q  <= '0;
            vld_q   <= '0;
            cnt_q   <= '0;
            filt_q  <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_key};
            vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            press_q <= 1'b0;
            if (vld_q[SYNC_STAGES-1] && !synced) begin
                armed_q <= 1'b1;
            end
            if (synced != filt_q) begin
                if (cnt_q == CNT_LAST) begin
                    filt_q  <= synced;
                    cnt_q   <= '0;
                    press_q <= synced & armed_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/tape_mode_ctl.sv
// IDLE/LOAD/SAVE tape mode FSM with FIFO-clear pulse; mode updates one edge after a debounced press; no backpressure.
// Define TAPE_MODE_AUTO_EXIT_EN to leave LOAD after TIMEOUT_CYCLES of empty FIFO.
module tape_mode_ctl
    import tape_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = TAPE_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_W       = TAPE_DEBOUNCE_W,
    parameter int unsigned DEBOUNCE_CYCLES  = TAPE_DEBOUNCE_CYCLES,
    parameter int unsigned CLR_PULSE_CYCLES = TAPE_CLR_PULSE_CYCLES,
    parameter int unsigned TIMEOUT_W        = TAPE_TIMEOUT_W,
    parameter int unsigned TIMEOUT_CYCLES   = TAPE_TIMEOUT_CYCLES
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_load_mode_tgl,
    input  logic       i_save_mode_tgl,
    input  logic       i_fifo_empty,
    output logic       o_load_mode,
    output logic       o_save_mode,
    output logic [1:0] o_mode,
    output logic       o_fifo_clear,
    output logic       o_mode_change,
    output logic       o_timeout
);

    localparam int unsigned       CLR_W    = $clog2(CLR_PULSE_CYCLES + 1);
    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_PULSE_CYCLES - 1);

    logic             ld_press, sv_press;
    logic             ld_only, sv_only;
    tape_mode_t       mode_q, mode_d;
    logic             tmo_fire, tmo_d, changing, clr_trig;
    logic             load_q, save_q, chg_q, clr_q, tmo_q;
    logic [CLR_W-1:0] clr_cnt_q;

    key_debounce #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_key (
        .i_clock(i_clock), .i_reset(i_reset), .i_key(i_load_mode_tgl), .o_press(ld_press)
    );

    key_debounce #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_save_key (
        .i_clock(i_clock), .i_reset(i_reset), .i_key(i_save_mode_tgl), .o_press(sv_press)
    );

    assign ld_only = ld_press & ~sv_press;
    assign sv_only = sv_press & ~ld_press;

`ifdef TAPE_MODE_AUTO_EXIT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_W-1:0] tmo_cnt_q;

    // Saturates so a timeout deferred by a same-cycle key press fires next cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset || changing || mode_q != MODE_LOAD || !i_fifo_empty) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_fire = (tmo_cnt_q == TMO_MAX);
`else
    logic                 unused_fifo_empty;
    logic [TIMEOUT_W-1:0] unused_tmo_cfg;

    assign unused_fifo_empty = i_fifo_empty;
    assign unused_tmo_cfg    = TIMEOUT_W'(TIMEOUT_CYCLES);
    assign tmo_fire          = 1'b0;
`endif

    always_comb begin
        mode_d = mode_q;
        tmo_d  = 1'b0;
        case (mode_q)
            MODE_IDLE: begin
                if (ld_only)      mode_d = MODE_LOAD;
                else if (sv_only) mode_d = MODE_SAVE;
            end
            MODE_LOAD: begin
                if (ld_only)      mode_d = MODE_IDLE;
                else if (sv_only) mode_d = MODE_SAVE;
                else if (!ld_press && !sv_press && tmo_fire) begin
                    mode_d = MODE_IDLE;
                    tmo_d  = 1'b1;
                end
            end
            MODE_SAVE: begin
                if (ld_only)      mode_d = MODE_LOAD;
                else if (sv_only) mode_d = MODE_IDLE;
            end
            default: mode_d = MODE_IDLE;
        endcase
    end

    assign changing = (mode_d != mode_q);
    assign clr_trig = changing && ((mode_d == MODE_LOAD) != (mode_q == MODE_LOAD));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mode_q    <= MODE_IDLE;
            load_q    <= 1'b0;
            save_q    <= 1'b0;
            chg_q     <= 1'b0;
            tmo_q     <= 1'b0;
            clr_q     <= 1'b0;
            clr_cnt_q <= '0;
        end else begin
            mode_q <= mode_d;
            load_q <= (mode_d == MODE_LOAD);
            save_q <= (mode_d == MODE_SAVE);
            chg_q  <= changing;
            tmo_q  <= tmo_d;
            if (clr_trig) begin
                clr_q     <= 1'b1;
                clr_cnt_q <= CLR_LAST;
            end else if (clr_cnt_q != '0) begin
                clr_q     <= 1'b1;
                clr_cnt_q <= clr_cnt_q - 1'b1;
            end else begin
                clr_q <= 1'b0;
            end
        end
    end

    assign o_mode        = mode_q;
    assign o_load_mode   = load_q;
    assign o_save_mode   = save_q;
    assign o_mode_change = chg_q;
    assign o_fifo_clear  = clr_q;
    assign o_timeout     = tmo_q;

endmodule
